// File: rtl/fsbm_pkg.sv
// Shared state encoding and width helpers for the FSBM controller, PE array and bench.
package fsbm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_e;

    // Signed coordinate width: room for +/-srP plus one spare bit
    function automatic int cwOf(input int srP);
        return $clog2(2 * srP + 1) + 1;
    endfunction

    function automatic int sadWOf(input int blkN);
        return 8 + 2 * $clog2(blkN);
    endfunction

endpackage

// File: rtl/fsbm_ctr_if.sv
// Signal bundle between fsbm_ctr and the PE array; the master side is the controller.
interface fsbm_ctr_if
    import fsbm_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int CW    = cwOf(8),
    parameter int SAD_W = sadWOf(16)
) ();

    logic                    start;
    logic                    turnenable;
    logic [SAD_W-1:0]        sad_in;
    logic [SEL_W-1:0]        select;
    logic                    load_ref;
    logic                    acc_en;
    logic                    pe_clear;
    logic signed [CW-1:0]    cand_x;
    logic signed [CW-1:0]    cand_y;
    logic                    sad_valid;
    logic                    busy;
    logic                    done;
    logic signed [CW-1:0]    mv_x;
    logic signed [CW-1:0]    mv_y;
    logic [SAD_W-1:0]        best_sad;

    modport master (
        input  start, turnenable, sad_in,
        output select, load_ref, acc_en, pe_clear, cand_x, cand_y,
               sad_valid, busy, done, mv_x, mv_y, best_sad
    );

    modport slave (
        output start, turnenable, sad_in,
        input  select, load_ref, acc_en, pe_clear, cand_x, cand_y,
               sad_valid, busy, done, mv_x, mv_y, best_sad
    );

endinterface

// File: rtl/fsbm_cand_cnt.sv
// Two-dimensional signed raster counter over the [-SR_P, +SR_P] candidate window.
module fsbm_cand_cnt
    import fsbm_pkg::*;
#(
    parameter int SR_P = 8,
    parameter int CW   = cwOf(SR_P)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_i,
    input  logic                 step_i,
    output logic signed [CW-1:0] x_o,
    output logic signed [CW-1:0] y_o,
    output logic                 last_o
);

    localparam logic signed [CW-1:0] MaxC = CW'(SR_P);
    localparam logic signed [CW-1:0] MinC = CW'(-SR_P);

    logic signed [CW-1:0] x_q, x_d, y_q, y_d;

    // x runs fastest; wrapping x carries into y
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (init_i) begin
            x_d = MinC;
            y_d = MinC;
        end else if (step_i) begin
            if (x_q == MaxC) begin
                x_d = MinC;
                y_d = y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == MaxC) && (y_q == MaxC);

endmodule

// File: rtl/fsbm_ctr.sv
// Sequencing controller for the FSBM PE array: loads the current block, sweeps the
// +/-SR_P candidate window in raster order and keeps the lowest-SAD displacement.
module fsbm_ctr
    import fsbm_pkg::*;
#(
    parameter int BLK_N = 16,
    parameter int SR_P  = 8,
    parameter int SEL_W = $clog2(BLK_N),
    parameter int CW    = cwOf(SR_P),
    parameter int SAD_W = sadWOf(BLK_N)
) (
    input  logic       clk,
    input  logic       rst_n,
    fsbm_ctr_if.master bus
);

    localparam logic [SEL_W-1:0] LastRow = SEL_W'(BLK_N - 1);

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     select_q, select_d;
    logic                 sadValid_q, done_q;
    logic signed [CW-1:0] sadCandX_q, sadCandY_q;
    logic signed [CW-1:0] mvX_q, mvX_d, mvY_q, mvY_d;
    logic [SAD_W-1:0]     bestSad_q, bestSad_d;
    logic signed [CW-1:0] candX, candY;
    logic                 candLast, candInit, candStep;
    logic                 loadRef, accEn, peClear, rowWrap, atLastRow;

    assign atLastRow = (select_q == LastRow);

    fsbm_cand_cnt #(
        .SR_P (SR_P),
        .CW   (CW)
    ) uCandCnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .init_i (candInit),
        .step_i (candStep),
        .x_o    (candX),
        .y_o    (candY),
        .last_o (candLast)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    if (candInit) state_d = SCAN;
            SCAN:    if (rowWrap && candLast) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A row is consumed only on enabled cycles; the wrap of the last row ends the block/candidate
    always_comb begin
        loadRef  = 1'b0;
        accEn    = 1'b0;
        candInit = 1'b0;
        rowWrap  = 1'b0;
        select_d = select_q;
        case (state_q)
            IDLE: if (bus.start) select_d = '0;
            LOAD: begin
                loadRef  = bus.turnenable;
                candInit = bus.turnenable && atLastRow;
            end
            SCAN: begin
                accEn   = bus.turnenable;
                rowWrap = bus.turnenable && atLastRow;
            end
            default: ;
        endcase
        if (loadRef || accEn) begin
            select_d = atLastRow ? '0 : select_q + SEL_W'(1);
        end
    end

    assign peClear  = accEn && (select_q == '0);
    assign candStep = rowWrap && !candLast;

    // Strict less-than keeps the earliest raster candidate on ties
    always_comb begin
        bestSad_d = bestSad_q;
        mvX_d     = mvX_q;
        mvY_d     = mvY_q;
        if (state_q == IDLE && bus.start) begin
            bestSad_d = '1;
            mvX_d     = '0;
            mvY_d     = '0;
        end else if (sadValid_q && (bus.sad_in < bestSad_q)) begin
            bestSad_d = bus.sad_in;
            mvX_d     = sadCandX_q;
            mvY_d     = sadCandY_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            select_q   <= '0;
            sadValid_q <= 1'b0;
            done_q     <= 1'b0;
            sadCandX_q <= '0;
            sadCandY_q <= '0;
            bestSad_q  <= '1;
            mvX_q      <= '0;
            mvY_q      <= '0;
        end else begin
            select_q   <= select_d;
            sadValid_q <= rowWrap;
            done_q     <= rowWrap && candLast;
            if (rowWrap) begin
                sadCandX_q <= candX;
                sadCandY_q <= candY;
            end
            bestSad_q  <= bestSad_d;
            mvX_q      <= mvX_d;
            mvY_q      <= mvY_d;
        end
    end

    assign bus.select    = select_q;
    assign bus.load_ref  = loadRef;
    assign bus.acc_en    = accEn;
    assign bus.pe_clear  = peClear;
    assign bus.cand_x    = candX;
    assign bus.cand_y    = candY;
    assign bus.sad_valid = sadValid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.mv_x      = mvX_q;
    assign bus.mv_y      = mvY_q;
    assign bus.best_sad  = bestSad_q;

endmodule

// File: doc/fsbm_ctr.md
# fsbm_ctr

Parametrised sequencing controller for the full-search block-matching (FSBM) processing-element array. On `start` it loads the current block row by row. It then sweeps every candidate displacement in a ±SR_P window in raster order, driving the row select, accumulator clear/enable and candidate coordinates into the PE array. It takes the SAD the array returns per candidate and tracks the minimum. It replaces the fixed 4-bit row selector with a generalised block size, search range and built-in best-match tracking.

## Interface
- `BLK_N`, 16: block side length in pixels; also rows per candidate; power of two, ≥ 2.
- `SR_P`, 8: search range; candidates dx, dy ∈ [−SR_P, +SR_P].
- `SEL_W`, $clog2(BLK_N): row-select width.
- `CW`, $clog2(2*SR_P+1)+1: signed coordinate width.
- `SAD_W`, 8+2*$clog2(BLK_N): SAD width.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a search; sampled only in IDLE.
- `turnenable` in 1: advance enable; low stalls all counters.
- `sad_in` in SAD_W: SAD from the array, valid when `sad_valid`=1.
- `select` out SEL_W: current row index.
- `load_ref` out 1: array loads current-block row `select`.
- `acc_en` out 1: array accumulates row `select` for the current candidate.
- `pe_clear` out 1: array clears its accumulators with this row.
- `cand_x`, `cand_y` out CW signed: current candidate displacement.
- `sad_valid` out 1: one-cycle pulse; the array must present the finished candidate's SAD on `sad_in` this cycle.
- `busy` out 1: high in LOAD, SCAN, DONE.
- `done` out 1: one-cycle completion pulse.
- `mv_x`, `mv_y` out CW signed: best displacement.
- `best_sad` out SAD_W: minimum SAD.

## Operation
- States: IDLE → LOAD → SCAN → DONE → IDLE.
- **IDLE**: `start`=1 → LOAD. On that edge: `select`=0, `best_sad`=all-ones, `mv`=0.
- **LOAD**: `load_ref`=`turnenable`. On each enabled cycle `select` increments. When `select`=BLK_N−1 with `turnenable`: `select`→0, `cand`→(−SR_P, −SR_P), go to SCAN.
- **SCAN**:
  - `acc_en`=`turnenable`; `pe_clear`=`acc_en` & (`select`=0).
  - On an enabled cycle with `select`=BLK_N−1: `select`→0, latch the current candidate into the internal `sad_cand`, set `sad_valid` next cycle.
  - The candidate then steps in raster order: dx++; when dx=+SR_P, dx→−SR_P and dy++.
  - The last candidate (+SR_P, +SR_P) completing → DONE.
- **DONE**: `done`=1 for one cycle, then IDLE. The `sad_valid` for the last candidate coincides with this cycle.
- **Best tracking**: when `sad_valid` & (`sad_in` < `best_sad`), update `best_sad`←`sad_in` and `mv`←`sad_cand`.
  - The comparison is strict, so on a tie the earliest candidate in raster order wins.
  - `mv`/`best_sad` hold from `done` until the next accepted `start`.
- `start` outside IDLE is ignored.
- `turnenable` low in SCAN freezes `select`/`cand` and forces `acc_en`/`pe_clear` low. A pending `sad_valid` still pulses exactly once.
- `turnenable` is ignored in IDLE and DONE.
- Coordinates are two's complement CW bits and never overflow by construction.
- Candidates per search: K=(2·SR_P+1)².

## Timing
- Reset values: state IDLE; `select`=0, `cand`=0, `mv`=0; `best_sad`=all-ones. `load_ref`, `acc_en`, `pe_clear`, `sad_valid`, `busy`, `done` = 0.
- `rst_n` low mid-search aborts at once to those values; no `done`.
- `select`, `cand_*`, `sad_valid`, `done`, `mv_*`, `best_sad` are registered.
- `load_ref`, `acc_en`, `pe_clear` are decoded from state, counters and `turnenable`.
- Without stalls, with `start` sampled at edge E0:
  - `load_ref` is high for cycles E0+1 … E0+BLK_N.
  - `sad_valid` for candidate k (0-based) is at E0+BLK_N+(k+1)·BLK_N+1.
  - `done` is at E0+BLK_N·(K+1)+1.
- Each stalled cycle adds one cycle to all later events.
- `busy` falls the cycle after `done`. A new `start` is accepted in that cycle.

## Structure
- Package `fsbm_pkg`:
  - state enum (IDLE, LOAD, SCAN, DONE);
  - functions for CW and SAD_W;
  - shared with the PE array and testbench.
- Sub-module `fsbm_cand_cnt`:
  - 2-D signed raster counter (init, step, last flag), parametrised by SR_P and CW;
  - instanced once.
- The FSM, row counter and best-match comparator stay in `fsbm_ctr`.

## Test plan
- BLK_N=4, SR_P=1, no stalls, `start` at E0 → `load_ref` E0+1..E0+4; nine `sad_valid` pulses at E0+9, +13, …, +41; `done` at E0+41.
- Same config, `sad_in` = 50 except candidate (+1, 0) = 7 → `mv`=(+1, 0), `best_sad`=7.
- Tie: candidates (−1, −1) and (0, +1) both 3 → `mv`=(−1, −1).
- `turnenable` low for 3 cycles mid-row of candidate 4 → `select`/`cand` frozen; `done` at E0+44; exactly nine `sad_valid` pulses.
- `rst_n` low during SCAN → all outputs at reset values asynchronously; `start` during SCAN ignored; restart completes normally.
- BLK_N=16, SR_P=8 → K=289 raster-ordered candidates; `done` at E0+4641; `cand` spans −8..+8.
